// File: rtl/pulse_shaper_if.sv
// pulse_shaper_if -- sample stream bundle between the symbol mapper and
// the I/Q pulse-shaping FIR.
//
// Signals
//   in_valid    sample strobe toward the shaper (mapper ready)
//   data_I_in   signed I sample into the shaper
//   data_Q_in   signed Q sample into the shaper
//   data_I_out  shaped signed I sample
//   data_Q_out  shaped signed Q sample
//   out_valid   data_*_out carry a new shaped sample this cycle
//
// Modports
//   master  producer side (drives inputs, observes shaped outputs)
//   slave   the shaper itself
`timescale 1ns/1ps

interface pulse_shaper_if #(
    parameter int WIDTH_DATA = 16
);
    logic                         in_valid;
    logic signed [WIDTH_DATA-1:0] data_I_in;
    logic signed [WIDTH_DATA-1:0] data_Q_in;
    logic signed [WIDTH_DATA-1:0] data_I_out;
    logic signed [WIDTH_DATA-1:0] data_Q_out;
    logic                         out_valid;

    modport master (
        output in_valid, data_I_in, data_Q_in,
        input  data_I_out, data_Q_out, out_valid
    );

    modport slave (
        input  in_valid, data_I_in, data_Q_in,
        output data_I_out, data_Q_out, out_valid
    );
endinterface

// File: rtl/pulse_shaper.sv
// pulse_shaper -- dual-rail (I/Q) symmetric 8-tap FIR pulse shaper with a
// small sequencer that flushes the delay line with zeros when the input
// stream stops.
//
// Ports
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    pulse_shaper_if.slave: in_valid, data_I_in, data_Q_in in;
//          data_I_out, data_Q_out, out_valid out
//
// Parameters
//   WIDTH_DATA  signed sample width in and out (default 16)
//   NTAPS       FIR length (default 8); coefficients beyond tap 7 are zero
//
// Build option
//   PULSE_SHAPER_SAT_EN  defined: out-of-range results clamp to the signed
//                        limits; undefined: results wrap (low WIDTH_DATA bits).
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no stream; delay line holds, shifts only on in_valid
// RUN   | stream active; shift every cycle
// FLUSH | stream stopped; shift zeros until the last sample leaves the taps
`timescale 1ns/1ps

module pulse_shaper #(
    parameter int WIDTH_DATA = 16,
    parameter int NTAPS      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pulse_shaper_if.slave  bus
);

    localparam int PROD_W = WIDTH_DATA + 16;
    localparam int ACC_W  = PROD_W + 3;
    localparam int RES_W  = ACC_W - 15;
    localparam int CNT_W  = (NTAPS > 2) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              flush_cnt;
    logic                          shift_d;
    logic signed [WIDTH_DATA-1:0]  x_i [NTAPS];
    logic signed [WIDTH_DATA-1:0]  x_q [NTAPS];

    logic                          shift_en;
    logic signed [WIDTH_DATA-1:0]  new_i;
    logic signed [WIDTH_DATA-1:0]  new_q;
    logic signed [ACC_W-1:0]       acc_i;
    logic signed [ACC_W-1:0]       acc_q;
    logic signed [RES_W-1:0]       res_i;
    logic signed [RES_W-1:0]       res_q;
    logic signed [WIDTH_DATA-1:0]  y_i;
    logic signed [WIDTH_DATA-1:0]  y_q;

    function automatic logic signed [15:0] coef(input int k);
        case (k)
            0, 7:    return -16'sd512;
            2, 5:    return 16'sd4096;
            3, 4:    return 16'sd12288;
            default: return 16'sd0;
        endcase
    endfunction

    // Outside IDLE the line shifts every cycle; a missing sample becomes zero.
    assign shift_en = bus.in_valid || (state != IDLE);
    assign new_i    = bus.in_valid ? bus.data_I_in : '0;
    assign new_q    = bus.in_valid ? bus.data_Q_in : '0;

    always_comb begin
        acc_i = '0;
        acc_q = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc_i = acc_i + ACC_W'(PROD_W'(x_i[k]) * PROD_W'(coef(k)));
            acc_q = acc_q + ACC_W'(PROD_W'(x_q[k]) * PROD_W'(coef(k)));
        end
    end

    // Dropping the low 15 bits of a signed value is an arithmetic shift that
    // rounds toward minus infinity.
    assign res_i = acc_i[ACC_W-1:15];
    assign res_q = acc_q[ACC_W-1:15];

    logic unused_lsb;
    assign unused_lsb = ^{acc_i[14:0], acc_q[14:0]};

`ifdef PULSE_SHAPER_SAT_EN
    function automatic logic signed [WIDTH_DATA-1:0] clamp(
        input logic signed [RES_W-1:0] r
    );
        logic [RES_W-WIDTH_DATA:0] top;
        top = r[RES_W-1:WIDTH_DATA-1];
        if ((&top) || !(|top))
            return r[WIDTH_DATA-1:0];
        else if (r[RES_W-1])
            return {1'b1, {(WIDTH_DATA-1){1'b0}}};
        else
            return {1'b0, {(WIDTH_DATA-1){1'b1}}};
    endfunction

    assign y_i = clamp(res_i);
    assign y_q = clamp(res_q);
`else
    assign y_i = res_i[WIDTH_DATA-1:0];
    assign y_q = res_q[WIDTH_DATA-1:0];

    logic unused_msb;
    assign unused_msb = ^{res_i[RES_W-1:WIDTH_DATA], res_q[RES_W-1:WIDTH_DATA]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            shift_d        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.data_I_out <= '0;
            bus.data_Q_out <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                x_i[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            // Output register samples the taps one edge after each shift.
            shift_d       <= shift_en;
            bus.out_valid <= shift_d;
            if (shift_d) begin
                bus.data_I_out <= y_i;
                bus.data_Q_out <= y_q;
            end

            if (shift_en) begin
                x_i[0] <= new_i;
                x_q[0] <= new_q;
                for (int k = 1; k < NTAPS; k++) begin
                    x_i[k] <= x_i[k-1];
                    x_q[k] <= x_q[k-1];
                end
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid)
                        state <= RUN;
                end
                RUN: begin
                    if (!bus.in_valid) begin
                        if (NTAPS <= 2) begin
                            state <= IDLE;
                        end else begin
                            flush_cnt <= CNT_W'(NTAPS - 2);
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.in_valid) begin
                        state <= RUN;
                    end else begin
                        // The shift that brings the counter to zero is the
                        // last one: NTAPS-1 zero shifts including RUN's.
                        flush_cnt <= flush_cnt - 1'b1;
                        if (flush_cnt <= CNT_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_shaper.sv
`timescale 1ns/1ps

module tb_pulse_shaper;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Impulse response to a 4096 sample: c_k * 4096 / 32768 = c_k / 8.
    int h  [8] = '{-64, 0, 512, 1536, 1536, 512, 0, -64};
    // Two 4096 impulses four shifts apart.
    int hd [12] = '{-64, 0, 512, 1536, 1472, 512, 512, 1472, 1536, 512, 0, -64};
    // Impulse response to -12288 (0xD000): -3 * h.
    int hq [8] = '{192, 0, -1536, -4608, -4608, -1536, 0, 192};

    pulse_shaper_if #(.WIDTH_DATA(16)) bus ();

    pulse_shaper #(.WIDTH_DATA(16), .NTAPS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int ei, input int eq);
        check({tag, ".valid"}, int'(bus.out_valid), v);
        check({tag, ".I"}, int'($signed(bus.data_I_out)), ei);
        check({tag, ".Q"}, int'($signed(bus.data_Q_out)), eq);
    endtask

    task automatic cyc(input logic v, input int si, input int sq);
        bus.in_valid  = v;
        bus.data_I_in = 16'(si);
        bus.data_Q_in = 16'(sq);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_I_in = '0;
        bus.data_Q_in = '0;

        // Reset, then idle with no strobe.
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("idle%0d", n), 0, 0, 0);
        end

        // I impulse.
        cyc(1'b1, 4096, 0);
        for (int n = 0; n < 8; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("imp_i%0d", n), 1, h[n], 0);
        end
        cyc(1'b0, 0, 0);
        check_out("imp_i_hold", 0, -64, 0);
        cyc(1'b0, 0, 0);
        check("imp_i_idle.valid", int'(bus.out_valid), 0);

        // Q impulse, I rail stays zero.
        cyc(1'b1, 0, -12288);
        for (int n = 0; n < 8; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("imp_q%0d", n), 1, 0, hq[n]);
        end
        cyc(1'b0, 0, 0);
        check_out("imp_q_hold", 0, 0, 192);

        // Drop in_valid for 3 cycles, then resume from FLUSH.
        cyc(1'b1, 4096, 0);
        cyc(1'b0, 0, 0);
        check_out("drop0", 1, hd[0], 0);
        cyc(1'b0, 0, 0);
        check_out("drop1", 1, hd[1], 0);
        cyc(1'b0, 0, 0);
        check_out("drop2", 1, hd[2], 0);
        cyc(1'b1, 4096, 0);
        check_out("drop3", 1, hd[3], 0);
        for (int n = 4; n < 12; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("drop%0d", n), 1, hd[n], 0);
        end
        cyc(1'b0, 0, 0);
        check("drop_idle.valid", int'(bus.out_valid), 0);

        // Full-scale stream: -32768, 32767 x6, -32768.
        cyc(1'b1, -32768, 0);
        cyc(1'b1, 32767, 0);
        check_out("sat0", 1, 512, 0);
        cyc(1'b1, 32767, 0);
        check_out("sat1", 1, -512, 0);
        repeat (4) cyc(1'b1, 32767, 0);
        cyc(1'b1, -32768, 0);
        cyc(1'b0, 0, 0);
`ifdef PULSE_SHAPER_SAT_EN
        check_out("sat7", 1, 32767, 0);
`else
        check_out("sat7", 1, -31745, 0);
`endif
        repeat (8) cyc(1'b0, 0, 0);
        check("sat_idle.valid", int'(bus.out_valid), 0);

        // Reset pulse in the middle of a flush.
        cyc(1'b1, 4096, 0);
        cyc(1'b0, 0, 0);
        check_out("rstf0", 1, -64, 0);
        cyc(1'b0, 0, 0);
        check_out("rstf1", 1, 0, 0);
        cyc(1'b0, 0, 0);
        check_out("rstf2", 1, 512, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rstf_async", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("rstf_quiet%0d", n), 0, 0, 0);
        end

        // Fresh impulse after reset: clean pipeline.
        cyc(1'b1, 4096, 0);
        for (int n = 0; n < 8; n++) begin
            cyc(1'b0, 0, 0);
            check_out($sformatf("post%0d", n), 1, h[n], 0);
        end
        cyc(1'b0, 0, 0);
        check("post_idle.valid", int'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
